// File: rtl/adder_pkg.sv
// Shared types and constants for the ripple-carry adder: default width,
// reset values of the registered result port and the result bundle.
package adder_pkg;

  localparam int WIDTH_DEF = 1;
  localparam int MAX_WIDTH = 64;

  localparam logic RST_VALID   = 1'b0;
  localparam logic RST_SUM_BIT = 1'b0;
  localparam logic RST_CO      = 1'b0;
  localparam logic RST_OVF     = 1'b0;
  localparam logic RST_ZERO    = 1'b1;

  // sum is carried at full width, zero-extended, so one type serves every WIDTH
  typedef struct packed {
    logic [MAX_WIDTH-1:0] sum;
    logic                 co;
    logic                 ovf;
    logic                 zero;
  } res_t;

endpackage

// File: rtl/adder_full_adder.sv
// One-bit full-adder cell; the multi-bit adder is a ripple chain of these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_p;

  assign w_p = a ^ b;
  assign s   = w_p ^ ci;
  assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/adder.sv
// Ripple-carry adder with a combinational sum/carry and an optional
// one-cycle registered result port carrying overflow and zero flags.
module adder
  import adder_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int REG_OUT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] S,
  output logic             co,
  input  logic             in_valid,
  output logic             out_valid,
  output logic [WIDTH-1:0] S_q,
  output logic             co_q,
  output logic             ovf_q,
  output logic             zero_q
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;
  res_t             w_res;

  assign w_c[0] = ci;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    full_adder u_fa (
      .a  (a[gi]),
      .b  (b[gi]),
      .ci (w_c[gi]),
      .s  (w_s[gi]),
      .co (w_c[gi+1])
    );
  end

  assign S  = w_s;
  assign co = w_c[WIDTH];

  // signed overflow: carry into the MSB disagrees with carry out of it
  always_comb begin
    w_res      = '0;
    w_res.sum  = MAX_WIDTH'(w_s);
    w_res.co   = w_c[WIDTH];
    w_res.ovf  = w_c[WIDTH] ^ w_c[WIDTH-1];
    w_res.zero = (w_res.sum == '0);
  end

  if (REG_OUT != 0) begin : g_reg
    logic             r_vld;
    logic [WIDTH-1:0] r_sq;
    logic             r_co;
    logic             r_ovf;
    logic             r_zero;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld  <= RST_VALID;
        r_sq   <= {WIDTH{RST_SUM_BIT}};
        r_co   <= RST_CO;
        r_ovf  <= RST_OVF;
        r_zero <= RST_ZERO;
      end else begin
        r_vld <= in_valid;
        if (in_valid) begin
          r_sq   <= w_res.sum[WIDTH-1:0];
          r_co   <= w_res.co;
          r_ovf  <= w_res.ovf;
          r_zero <= w_res.zero;
        end
      end
    end

    assign out_valid = r_vld;
    assign S_q       = r_sq;
    assign co_q      = r_co;
    assign ovf_q     = r_ovf;
    assign zero_q    = r_zero;
  end else begin : g_noreg
    assign out_valid = RST_VALID;
    assign S_q       = {WIDTH{RST_SUM_BIT}};
    assign co_q      = RST_CO;
    assign ovf_q     = RST_OVF;
    assign zero_q    = RST_ZERO;
  end

endmodule

// File: tb/tb_adder.sv
// Directed bench for adder: 1-bit combinational sweep plus 8-bit registered path.
module tb_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       a1, b1, ci1, s1, co1, iv1;
  logic       ov1, sq1, coq1, ovfq1, zq1;

  logic [7:0] a8, b8, s8, sq8;
  logic       ci8, co8, iv8, ov8, coq8, ovfq8, zq8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  adder #(.WIDTH(1), .REG_OUT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .ci(ci1), .S(s1), .co(co1),
    .in_valid(iv1), .out_valid(ov1), .S_q(sq1), .co_q(coq1), .ovf_q(ovfq1), .zero_q(zq1)
  );

  adder #(.WIDTH(8), .REG_OUT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci8), .S(s8), .co(co8),
    .in_valid(iv8), .out_valid(ov8), .S_q(sq8), .co_q(coq8), .ovf_q(ovfq8), .zero_q(zq8)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic v, input logic [7:0] s,
                         input logic c, input logic o, input logic z);
    chk({tag, ".vld"},  ov8,   v);
    chk({tag, ".sq"},   sq8,   s);
    chk({tag, ".co"},   coq8,  c);
    chk({tag, ".ovf"},  ovfq8, o);
    chk({tag, ".zero"}, zq8,   z);
  endtask

  // a, b, ci -> S, co for the 1-bit cell, worked out by hand
  logic [4:0] tt [8] = '{
    5'b000_00, 5'b001_10, 5'b010_10, 5'b011_01,
    5'b100_10, 5'b101_01, 5'b110_01, 5'b111_11
  };

  initial begin
    a1 = 0; b1 = 0; ci1 = 0; iv1 = 0;
    a8 = 0; b8 = 0; ci8 = 0; iv8 = 0;

    #1 rst_n = 1'b0;
    #1;
    chk_reg("rst0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 8; i++) begin
      {a1, b1, ci1} = tt[i][4:2];
      #10;
      chk($sformatf("w1.S[%0d]", i),  s1,  tt[i][1]);
      chk($sformatf("w1.co[%0d]", i), co1, tt[i][0]);
    end

    @(negedge clk);
    rst_n = 1'b1;

    a8 = 8'hFF; b8 = 8'h01; ci8 = 0; iv8 = 1;
    @(negedge clk);
    chk_reg("ff+01", 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    a8 = 8'h7F; b8 = 8'h01; ci8 = 0;
    @(negedge clk);
    chk_reg("7f+01", 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);

    a8 = 8'hFF; b8 = 8'hFF; ci8 = 1;
    #1;
    chk("wrap.S", s8, 8'hFF);
    chk("wrap.co", co8, 1'b1);
    @(negedge clk);
    chk_reg("wrap", 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);

    // back-to-back burst of three, then idle
    a8 = 8'h10; b8 = 8'h20; ci8 = 0;
    @(negedge clk);
    chk_reg("b2b0", 1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    a8 = 8'h80; b8 = 8'h80; ci8 = 0;
    @(negedge clk);
    chk_reg("b2b1", 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
    a8 = 8'h05; b8 = 8'h0A; ci8 = 1;
    @(negedge clk);
    chk_reg("b2b2", 1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
    iv8 = 0; a8 = 8'h33; b8 = 8'h44;
    @(negedge clk);
    chk_reg("idle", 1'b0, 8'h10, 1'b0, 1'b0, 1'b0);

    // reset between edges while a result is valid
    iv8 = 1; a8 = 8'hC0; b8 = 8'h50; ci8 = 0;
    @(posedge clk);
    #2;
    chk_reg("pre", 1'b1, 8'h10, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reg("mid", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("mid.S", s8, 8'h10);
    a8 = 8'h12; b8 = 8'h34; ci8 = 1;
    #1;
    chk("mid.S2", s8, 8'h47);
    chk("mid.co", co8, 1'b0);

    @(negedge clk);
    iv8 = 0;
    rst_n = 1'b1;
    @(negedge clk);
    chk_reg("post0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    iv8 = 1; a8 = 8'h01; b8 = 8'h01; ci8 = 0;
    @(negedge clk);
    chk_reg("post1", 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
